// File: rtl/pc_sequencer_if.sv
// PC sequencer bus: control and redirect targets in, fetch PC and status out.
// The master side drives control, and the slave side is the sequencer.
interface pc_sequencer_if #(
    parameter int WIDTH = 12
);
    logic             stall;
    logic [1:0]       sel;
    logic [WIDTH-1:0] data_branch;
    logic [WIDTH-1:0] data_jump;
    logic [WIDTH-1:0] data_jr;
    logic [WIDTH-1:0] pc_out;
    logic [WIDTH-1:0] pc_plus;
    logic             valid;
    logic             flush;
    logic             pending;

    modport master (
        output stall, sel, data_branch, data_jump, data_jr,
        input  pc_out, pc_plus, valid, flush, pending
    );

    modport slave (
        input  stall, sel, data_branch, data_jump, data_jr,
        output pc_out, pc_plus, valid, flush, pending
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter sequencer with stall hold and one deferred redirect.
// A redirect seen during a stall is parked and applied when the stall drops.
module pc_sequencer #(
    parameter int               WIDTH     = 12,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter logic [WIDTH-1:0] INC       = WIDTH'(1)
) (
    input logic         clock,
    input logic         reset,
    pc_sequencer_if.slave bus
);
    localparam logic [1:0] INIT      = 2'b00;
    localparam logic [1:0] RUN       = 2'b01;
    localparam logic [1:0] HOLD      = 2'b10;
    localparam logic [1:0] HOLD_PEND = 2'b11;

    logic [1:0]       state;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pend_q;
    logic [WIDTH-1:0] pc_plus;
    logic [WIDTH-1:0] target;
    logic             flush_q;
    logic             redirect;

    assign pc_plus  = pc_q + INC;
    assign redirect = (bus.sel != 2'b00);

    always_comb begin
        target = pc_plus;
        unique case (1'b1)
            (bus.sel == 2'b00): target = pc_plus;
            (bus.sel == 2'b01): target = bus.data_branch;
            (bus.sel == 2'b10): target = bus.data_jump;
            (bus.sel == 2'b11): target = bus.data_jr;
            default:            target = pc_plus;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= INIT;
            pc_q    <= RESET_VEC;
            pend_q  <= '0;
            flush_q <= 1'b0;
        end else begin
            flush_q <= 1'b0;
            case (state)
                INIT: begin
                    state <= RUN;
                end
                RUN, HOLD: begin
                    if (!bus.stall) begin
                        pc_q    <= target;
                        flush_q <= redirect;
                        state   <= RUN;
                    end else if (redirect) begin
                        pend_q <= target;
                        state  <= HOLD_PEND;
                    end else begin
                        state <= HOLD;
                    end
                end
                HOLD_PEND: begin
                    // A fresh redirect outranks the parked one.
                    if (!bus.stall) begin
                        pc_q    <= redirect ? target : pend_q;
                        pend_q  <= '0;
                        flush_q <= 1'b1;
                        state   <= RUN;
                    end else if (redirect) begin
                        pend_q <= target;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

    assign bus.pc_out  = pc_q;
    assign bus.pc_plus = pc_plus;
    assign bus.valid   = (state != INIT);
    assign bus.flush   = flush_q;
    assign bus.pending = (state == HOLD_PEND);
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer at WIDTH=12, RESET_VEC=0, INC=1.
module tb_pc_sequencer;
    localparam int W = 12;

    logic clock;
    logic reset;
    int   total;
    int   passed;

    pc_sequencer_if #(.WIDTH(W)) bus ();

    pc_sequencer #(
        .WIDTH(W),
        .RESET_VEC(12'h000),
        .INC(12'h001)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drive(input logic st, input logic [1:0] s,
                         input logic [W-1:0] br, input logic [W-1:0] jp,
                         input logic [W-1:0] jr);
        bus.stall       = st;
        bus.sel         = s;
        bus.data_branch = br;
        bus.data_jump   = jp;
        bus.data_jr     = jr;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        reset  = 1'b0;
        drive(1'b0, 2'b00, 12'h0, 12'h0, 12'h0);
        #1;
        chk("rst_pc", 32'(bus.pc_out), 32'h000);
        chk("rst_valid", 32'(bus.valid), 32'h0);
        chk("rst_flush", 32'(bus.flush), 32'h0);
        chk("rst_pending", 32'(bus.pending), 32'h0);

        @(negedge clock);
        reset = 1'b1;
        step();
        chk("init_pc", 32'(bus.pc_out), 32'h000);
        chk("init_valid", 32'(bus.valid), 32'h1);
        chk("init_flush", 32'(bus.flush), 32'h0);
        step();
        chk("seq1_pc", 32'(bus.pc_out), 32'h001);
        step();
        chk("seq2_pc", 32'(bus.pc_out), 32'h002);
        chk("seq2_plus", 32'(bus.pc_plus), 32'h003);

        drive(1'b0, 2'b10, 12'h0, 12'hFFE, 12'h0);
        step();
        chk("jmp_pc", 32'(bus.pc_out), 32'hFFE);
        chk("jmp_flush", 32'(bus.flush), 32'h1);
        drive(1'b0, 2'b00, 12'h0, 12'h0, 12'h0);
        step();
        chk("wrap1_pc", 32'(bus.pc_out), 32'hFFF);
        chk("wrap1_flush", 32'(bus.flush), 32'h0);
        chk("wrap1_plus", 32'(bus.pc_plus), 32'h000);
        step();
        chk("wrap2_pc", 32'(bus.pc_out), 32'h000);
        chk("wrap2_flush", 32'(bus.flush), 32'h0);

        drive(1'b0, 2'b01, 12'h123, 12'h0, 12'h0);
        step();
        chk("br_pc", 32'(bus.pc_out), 32'h123);
        chk("br_flush", 32'(bus.flush), 32'h1);
        drive(1'b0, 2'b00, 12'h0, 12'h0, 12'h0);
        step();
        chk("br_next_pc", 32'(bus.pc_out), 32'h124);
        chk("br_next_flush", 32'(bus.flush), 32'h0);

        drive(1'b1, 2'b10, 12'h0, 12'h040, 12'h0);
        step();
        chk("stj_pc", 32'(bus.pc_out), 32'h124);
        chk("stj_pending", 32'(bus.pending), 32'h1);
        chk("stj_valid", 32'(bus.valid), 32'h1);
        chk("stj_flush", 32'(bus.flush), 32'h0);
        drive(1'b1, 2'b11, 12'h0, 12'h0, 12'h080);
        step();
        chk("stjr_pc", 32'(bus.pc_out), 32'h124);
        chk("stjr_pending", 32'(bus.pending), 32'h1);
        drive(1'b0, 2'b00, 12'h0, 12'h0, 12'h0);
        step();
        chk("apply_pc", 32'(bus.pc_out), 32'h080);
        chk("apply_pending", 32'(bus.pending), 32'h0);
        chk("apply_flush", 32'(bus.flush), 32'h1);
        step();
        chk("post_pc", 32'(bus.pc_out), 32'h081);
        chk("post_flush", 32'(bus.flush), 32'h0);

        drive(1'b1, 2'b00, 12'h0, 12'h0, 12'h0);
        step();
        chk("hold1_pc", 32'(bus.pc_out), 32'h081);
        chk("hold1_pending", 32'(bus.pending), 32'h0);
        step();
        chk("hold2_pc", 32'(bus.pc_out), 32'h081);
        chk("hold2_valid", 32'(bus.valid), 32'h1);
        drive(1'b0, 2'b00, 12'h0, 12'h0, 12'h0);
        step();
        chk("unhold_pc", 32'(bus.pc_out), 32'h082);
        chk("unhold_flush", 32'(bus.flush), 32'h0);

        drive(1'b1, 2'b11, 12'h0, 12'h0, 12'h080);
        step();
        chk("prio_pending", 32'(bus.pending), 32'h1);
        drive(1'b0, 2'b01, 12'h200, 12'h0, 12'h0);
        step();
        chk("prio_pc", 32'(bus.pc_out), 32'h200);
        chk("prio_pending0", 32'(bus.pending), 32'h0);
        chk("prio_flush", 32'(bus.flush), 32'h1);

        drive(1'b0, 2'b01, 12'h200, 12'h0, 12'h0);
        step();
        chk("self_pc", 32'(bus.pc_out), 32'h200);
        chk("self_flush", 32'(bus.flush), 32'h1);
        drive(1'b0, 2'b00, 12'h0, 12'h0, 12'h0);
        step();
        chk("self_next_pc", 32'(bus.pc_out), 32'h201);

        drive(1'b1, 2'b10, 12'h0, 12'h300, 12'h0);
        step();
        drive(1'b1, 2'b00, 12'h0, 12'h0, 12'h0);
        step();
        chk("keep_pending", 32'(bus.pending), 32'h1);
        chk("keep_pc", 32'(bus.pc_out), 32'h201);
        drive(1'b0, 2'b00, 12'h0, 12'h0, 12'h0);
        step();
        chk("keep_apply_pc", 32'(bus.pc_out), 32'h300);
        chk("keep_apply_flush", 32'(bus.flush), 32'h1);

        drive(1'b1, 2'b10, 12'h0, 12'h555, 12'h0);
        step();
        chk("arst_pre_pending", 32'(bus.pending), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_pc", 32'(bus.pc_out), 32'h000);
        chk("arst_pending", 32'(bus.pending), 32'h0);
        chk("arst_valid", 32'(bus.valid), 32'h0);
        chk("arst_flush", 32'(bus.flush), 32'h0);
        drive(1'b0, 2'b01, 12'h777, 12'h0, 12'h0);
        step();
        chk("inrst_pc", 32'(bus.pc_out), 32'h000);
        chk("inrst_valid", 32'(bus.valid), 32'h0);
        reset = 1'b1;
        step();
        chk("reinit_pc", 32'(bus.pc_out), 32'h000);
        chk("reinit_flush", 32'(bus.flush), 32'h0);
        chk("reinit_valid", 32'(bus.valid), 32'h1);
        drive(1'b0, 2'b00, 12'h0, 12'h0, 12'h0);
        step();
        chk("reinit_seq_pc", 32'(bus.pc_out), 32'h001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have the parameter WIDTH, default 12, giving the PC and target width in bits.
REQ-002 The block SHALL have the parameter RESET_VEC, default 0, giving the PC value loaded at reset.
REQ-003 The block SHALL have the parameter INC, default 1, giving the sequential PC increment.
REQ-004 The block SHALL have the port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have the port reset, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have the port stall, input, 1 bit: when high, the PC holds its value.
REQ-007 The block SHALL have the port sel, input, 2 bits, encoded 00 sequential, 01 branch, 10 jump, 11 jr.
REQ-008 The block SHALL have the port data_branch, input, WIDTH bits: the branch target.
REQ-009 The block SHALL have the port data_jump, input, WIDTH bits: the jump target.
REQ-010 The block SHALL have the port data_jr, input, WIDTH bits: the register-jump target.
REQ-011 The block SHALL have the port pc_out, output, WIDTH bits: the current PC.
REQ-012 The block SHALL have the port pc_plus, output, WIDTH bits, equal to pc_out+INC modulo 2^WIDTH (combinational).
REQ-013 The block SHALL have the port valid, output, 1 bit: high when pc_out is a legal fetch address.
REQ-014 The block SHALL have the port flush, output, 1 bit: a one-cycle pulse after a redirect is applied.
REQ-015 The block SHALL have the port pending, output, 1 bit: high while a redirect captured during a stall awaits application.

Function
REQ-016 The block SHALL select the target combinationally: 00 gives pc_plus, 01 data_branch, 10 data_jump, 11 data_jr.
REQ-017 The block SHALL implement the states INIT, RUN, HOLD and HOLD_PEND, encoded in 2 bits.
REQ-018 In INIT, the first rising edge after reset deasserts SHALL move the state to RUN with valid=1, leave pc_out=RESET_VEC, and apply no redirect.
REQ-019 In RUN with stall=0, the block SHALL load the selected target into pc_out on the edge, i.e. 1-cycle latency from sel/data to pc_out.
REQ-020 In RUN with stall=0 and sel!=00, flush SHALL be 1 in the following cycle; otherwise flush SHALL be 0.
REQ-021 In RUN with stall=1 and sel=00, the block SHALL hold pc_out and move to HOLD.
REQ-022 In RUN or HOLD with stall=1 and sel!=00, the block SHALL capture the selected target into the pending register, set pending=1, hold pc_out and move to HOLD_PEND.
REQ-023 In HOLD_PEND with stall=1 and sel!=00, the newest target SHALL overwrite the pending register; with sel=00, the pending register SHALL be kept.
REQ-024 In HOLD with stall=0, the block SHALL behave as RUN for that cycle: load the selected target and return to RUN.
REQ-025 In HOLD_PEND with stall=0 and sel=00, the block SHALL load the pending target into pc_out, clear pending, pulse flush and return to RUN.
REQ-026 In HOLD_PEND with stall=0 and sel!=00, the current sel target SHALL take priority over the pending one: load it, clear pending, pulse flush and return to RUN.
REQ-027 pc_plus and the sequential target SHALL wrap modulo 2^WIDTH; for example, 0xFFF+1 gives 0x000 at WIDTH=12.
REQ-028 A redirect whose target equals the current PC SHALL still pulse flush.
REQ-029 valid SHALL remain 1 in HOLD and HOLD_PEND.

Reset
REQ-030 Asserting reset at any time, including mid-stall with pending=1, SHALL immediately force state=INIT, pc_out=RESET_VEC, pending register=0, pending=0, flush=0 and valid=0.
REQ-031 While reset is low, all inputs SHALL be ignored.

Verification
REQ-032 Reset release then 3 edges with sel=00 and stall=0 (WIDTH=12, RESET_VEC=0) -> pc_out goes 0,0,1,2 and valid rises after the first edge.
REQ-033 pc_out=0xFFE, sel=00 for 2 cycles -> pc_out=0xFFF then 0x000, and flush stays 0.
REQ-034 sel=01, data_branch=0x123, stall=0 -> next cycle pc_out=0x123 and flush=1 for exactly one cycle.
REQ-035 stall=1 with sel=10 and data_jump=0x040, then sel=11 and data_jr=0x080, then stall=0 with sel=00 -> pending=1 during the stall, then pc_out=0x080, pending=0 and flush=1.
REQ-036 HOLD_PEND holding target 0x080, stall drops with sel=01 and data_branch=0x200 -> pc_out=0x200 and pending=0.
REQ-037 reset asserted asynchronously between edges in HOLD_PEND -> pc_out=RESET_VEC, pending=0 and valid=0 before the next clock edge.
